uart_core_param: RTL and testbench

//  Parametrised UART core with integrated oversampling baud generator, transmitter and receiver.

---
 rtl/uart_core_param.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_core_param.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core_param.sv
// rtl/uart_core_param.sv - parametrised UART core: oversampling baud generator, TX, RX, error flags
// Optional frame parity bit is compiled in with UART_PARITY_EN.
module uart_core_param #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 loopback,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 txd,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);

`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam bit PAR_ODD = (PARITY_ODD != 0);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE) - 1;
  localparam int BW  = (DIV > 0) ? $clog2(DIV + 1) : 1;
  localparam int OW  = $clog2(OVERSAMPLE);
  localparam int IW  = $clog2(DATA_BITS);
  localparam logic [BW-1:0] DIV_LAST  = BW'(DIV);
  localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] OS_HALF   = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  logic [BW-1:0] baud_cnt;
  logic          os_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      os_tick  <= 1'b0;
    end else if (baud_cnt == DIV_LAST) begin
      baud_cnt <= '0;
      os_tick  <= 1'b1;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
      os_tick  <= 1'b0;
    end
  end

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  tx_state_t            tx_state;
  logic [DATA_BITS-1:0] tx_shreg;
  logic [OW-1:0]        tx_cnt;
  logic [IW-1:0]        tx_bit;
  logic                 tx_stop;
  logic                 tx_par;
  logic                 tx_line;

  // Loopback keeps the pin idle; the internal line still carries the frame to RX.
  assign txd = loopback ? 1'b1 : tx_line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_shreg <= '0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_stop  <= 1'b0;
      tx_par   <= 1'b0;
      tx_line  <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (tx_state == TX_IDLE) begin
        if (tx_start) begin
          tx_shreg <= tx_data;
          tx_par   <= (^tx_data) ^ PAR_ODD;
          tx_line  <= 1'b0;
          tx_cnt   <= '0;
          tx_busy  <= 1'b1;
          tx_state <= TX_START;
        end
      end else if (os_tick) begin
        if (tx_cnt != OS_LAST) begin
          tx_cnt <= tx_cnt + 1'b1;
        end else begin
          tx_cnt <= '0;
          case (tx_state)
            TX_START: begin
              tx_line  <= tx_shreg[0];
              tx_bit   <= '0;
              tx_state <= TX_DATA;
            end
            TX_DATA: begin
              if (tx_bit != BIT_LAST) begin
                tx_shreg <= {1'b0, tx_shreg[DATA_BITS-1:1]};
                tx_line  <= tx_shreg[1];
                tx_bit   <= tx_bit + 1'b1;
              end else if (PAR_EN) begin
                tx_line  <= tx_par;
                tx_state <= TX_PARITY;
              end else begin
                tx_line  <= 1'b1;
                tx_stop  <= 1'b0;
                tx_state <= TX_STOP;
              end
            end
            TX_PARITY: begin
              tx_line  <= 1'b1;
              tx_stop  <= 1'b0;
              tx_state <= TX_STOP;
            end
            TX_STOP: begin
              if (tx_stop == STOP_LAST) begin
                tx_busy  <= 1'b0;
                tx_done  <= 1'b1;
                tx_state <= TX_IDLE;
              end else begin
                tx_stop <= 1'b1;
              end
            end
            default: tx_state <= TX_IDLE;
          endcase
        end
      end
    end
  end

  logic rx_meta, rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= loopback ? tx_line : rxd;
      rx_s    <= rx_meta;
    end
  end

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT} rx_state_t;
  rx_state_t            rx_state;
  logic [DATA_BITS-1:0] rx_shreg;
  logic [OW-1:0]        rx_cnt;
  logic [IW-1:0]        rx_bit;
  logic                 rx_par_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state      <= RX_IDLE;
      rx_shreg      <= '0;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_par_bit    <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (os_tick) begin
        case (rx_state)
          RX_IDLE: begin
            if (!rx_s) begin
              rx_cnt   <= '0;
              rx_state <= RX_START;
            end
          end
          // Half-bit recheck rejects glitches and centres all later samples.
          RX_START: begin
            if (rx_cnt == OS_HALF) begin
              rx_cnt   <= '0;
              rx_bit   <= '0;
              rx_state <= rx_s ? RX_IDLE : RX_DATA;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
          RX_DATA: begin
            if (rx_cnt == OS_LAST) begin
              rx_cnt   <= '0;
              rx_shreg <= {rx_s, rx_shreg[DATA_BITS-1:1]};
              if (rx_bit == BIT_LAST) rx_state <= PAR_EN ? RX_PARITY : RX_STOP;
              else                    rx_bit   <= rx_bit + 1'b1;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
          RX_PARITY: begin
            if (rx_cnt == OS_LAST) begin
              rx_cnt     <= '0;
              rx_par_bit <= rx_s;
              rx_state   <= RX_STOP;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
          RX_STOP: begin
            if (rx_cnt == OS_LAST) begin
              rx_cnt        <= '0;
              rx_data       <= rx_shreg;
              rx_frame_err  <= !rx_s;
              rx_parity_err <= PAR_EN && (rx_par_bit != ((^rx_shreg) ^ PAR_ODD));
              rx_valid      <= 1'b1;
              rx_state      <= rx_s ? RX_IDLE : RX_WAIT;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
          RX_WAIT: if (rx_s) rx_state <= RX_IDLE;
          default: rx_state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_core_param.sv
// tb/tb_uart_core_param.sv - directed self-checking bench for uart_core_param
// Parity-specific checks run when UART_PARITY_EN is defined.
module tb_uart_core_param;
  localparam int OS = 16;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FRAME = 10 + PB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       loopback = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rxd = 1'b1;
  logic       tx_busy, tx_done, txd;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err, rx_parity_err;

  uart_core_param #(
    .CLK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16),
    .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .loopback(loopback), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done), .txd(txd),
    .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         rx_n = 0;
  int         txd_low_n = 0;
  logic [7:0] last_data = 8'h00;
  logic       last_fe = 1'b0;
  logic       last_pe = 1'b0;
  logic [7:0] rx_hist[$];

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_n++;
      last_data = rx_data;
      last_fe   = rx_frame_err;
      last_pe   = rx_parity_err;
      rx_hist.push_back(rx_data);
    end
    if (loopback && !txd) txd_low_n++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bit b of the result is the line level during bit time b (start bit first).
  function automatic logic [11:0] make_frame(input logic [7:0] d, input logic par_bad,
                                             input logic stop_v);
    logic [11:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (PB == 1) begin
      f[9]  = (^d) ^ par_bad;
      f[10] = stop_v;
    end else begin
      f[9] = stop_v;
    end
    return f;
  endfunction

  task automatic drive_rx(input logic [11:0] f);
    for (int b = 0; b < FRAME; b++) begin
      rxd = f[b];
      repeat (OS) @(negedge clk);
    end
  endtask

  task automatic wait_done(input string tag, output int cycles);
    cycles = 0;
    while (!tx_done && cycles < 400) begin
      @(negedge clk);
      cycles++;
    end
    check(tag, tx_done, 1'b1);
  endtask

  task automatic tx_and_check(input logic [7:0] d);
    logic [11:0] f;
    int          w;
    f = make_frame(d, 1'b0, 1'b1);
    @(negedge clk); tx_start = 1'b1; tx_data = d;
    @(negedge clk); tx_start = 1'b0;
    repeat (OS / 2) @(negedge clk);
    for (int b = 0; b < FRAME; b++) begin
      check($sformatf("txd_%0h_bit%0d", d, b), txd, f[b]);
      if (b < FRAME - 1) repeat (OS) @(negedge clk);
    end
    wait_done($sformatf("txd_%0h_done", d), w);
    @(negedge clk);
    check($sformatf("txd_%0h_idle", d), txd, 1'b1);
  endtask

  initial begin
    int n0, busy_n, guard, gap;

    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_tx_busy", tx_busy, 1'b0);
    check("rst_tx_done", tx_done, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_frame_err", rx_frame_err, 1'b0);
    check("rst_parity_err", rx_parity_err, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Loopback: the frame reaches RX while the pin stays idle.
    loopback = 1'b1;
    txd_low_n = 0;
    n0 = rx_n;
    @(negedge clk); tx_start = 1'b1; tx_data = 8'hA5;
    @(negedge clk); tx_start = 1'b0;
    busy_n = 0;
    guard = 0;
    while (!tx_done && guard < 400) begin
      if (tx_busy) busy_n++;
      @(negedge clk);
      guard++;
    end
    check("lb_done_seen", tx_done, 1'b1);
    check("lb_busy_in_done", tx_busy, 1'b0);
    check("lb_busy_cycles", busy_n, FRAME * OS);
    @(negedge clk);
    check("lb_done_pulse", tx_done, 1'b0);
    repeat (20) @(negedge clk);
    check("lb_rx_count", rx_n - n0, 1);
    check("lb_rx_data", last_data, 8'hA5);
    check("lb_frame_err", last_fe, 1'b0);
    check("lb_parity_err", last_pe, 1'b0);
    check("lb_txd_low", txd_low_n, 0);
    loopback = 1'b0;
    repeat (10) @(negedge clk);

    // Framing error followed by a break, then a clean frame.
    n0 = rx_n;
    drive_rx(make_frame(8'h3C, 1'b0, 1'b0));
    repeat (40) @(negedge clk);
    check("fe_rx_count", rx_n - n0, 1);
    check("fe_rx_data", last_data, 8'h3C);
    check("fe_frame_err", last_fe, 1'b1);
    check("fe_parity_err", last_pe, 1'b0);
    rxd = 1'b1;
    repeat (32) @(negedge clk);
    drive_rx(make_frame(8'h55, 1'b0, 1'b1));
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    check("clean_rx_count", rx_n - n0, 2);
    check("clean_rx_data", last_data, 8'h55);
    check("clean_frame_err", last_fe, 1'b0);
    check("clean_parity_err", last_pe, 1'b0);

    // Short glitch is not a start bit.
    n0 = rx_n;
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_no_rx", rx_n - n0, 0);
    drive_rx(make_frame(8'hC3, 1'b0, 1'b1));
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    check("post_glitch_count", rx_n - n0, 1);
    check("post_glitch_data", last_data, 8'hC3);

    tx_and_check(8'h07);
`ifdef UART_PARITY_EN
    n0 = rx_n;
    drive_rx(make_frame(8'h07, 1'b1, 1'b1));
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    check("par_rx_count", rx_n - n0, 1);
    check("par_rx_data", last_data, 8'h07);
    check("par_parity_err", last_pe, 1'b1);
    check("par_frame_err", last_fe, 1'b0);
`endif

    // Busy ignores tx_start; back-to-back frames from the tx_done cycle.
    loopback = 1'b1;
    n0 = rx_n;
    @(negedge clk); tx_start = 1'b1; tx_data = 8'h01;
    @(negedge clk); tx_data = 8'hFF;
    repeat (50) @(negedge clk);
    tx_start = 1'b0;
    wait_done("b2b_done1", guard);
    tx_start = 1'b1; tx_data = 8'h02;
    @(negedge clk); tx_start = 1'b0;
    gap = 1;
    while (!tx_done && gap < 400) begin
      @(negedge clk);
      gap++;
    end
    check("b2b_gap", gap, FRAME * OS + 1);
    repeat (20) @(negedge clk);
    check("b2b_rx_count", rx_n - n0, 2);
    check("b2b_first", rx_hist[n0], 8'h01);
    check("b2b_second", rx_hist[n0 + 1], 8'h02);
    loopback = 1'b0;
    repeat (10) @(negedge clk);

    // Reset in the middle of the data bits.
    @(negedge clk); tx_start = 1'b1; tx_data = 8'hF0;
    @(negedge clk); tx_start = 1'b0;
    repeat (60) @(negedge clk);
    check("rst_mid_pre_txd", txd, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_txd", txd, 1'b1);
    check("rst_mid_busy", tx_busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tx_and_check(8'h81);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
